// File: rtl/seq_alu_pkg.sv
// Shared constants for the sequential ALU: opcodes, FSM state type and WIDTH bounds.
package seq_alu_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

    localparam logic [4:0] OP_SHL = 5'b00000;
    localparam logic [4:0] OP_ADD = 5'b00010;
    localparam logic [4:0] OP_SUB = 5'b00011;
    localparam logic [4:0] OP_MUL = 5'b00100;
    localparam logic [4:0] OP_DIV = 5'b00110;
    localparam logic [4:0] OP_AND = 5'b01000;
    localparam logic [4:0] OP_OR  = 5'b01100;
    localparam logic [4:0] OP_SHR = 5'b10000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative shift-add multiplier and restoring divider, one step per cycle for WIDTH cycles.
// The divider is only built when SEQ_ALU_DIVIDE_EN is defined.
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             load,
    input  logic             step,
`ifdef SEQ_ALU_DIVIDE_EN
    input  logic             div,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] hi_nx,
    output logic [WIDTH-1:0] lo_nx
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;

    // Multiply: {acc_hi, acc_lo} is the product/multiplier pair, shifted right each step.
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};

`ifdef SEQ_ALU_DIVIDE_EN
    logic             is_div;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;

    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    // A zero divisor naturally yields all-ones quotient and remainder equal to the dividend.
    assign div_sh = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge = (div_sh >= {1'b0, opnd});
    assign div_hi = div_ge ? (div_sh[WIDTH-1:0] - opnd) : div_sh[WIDTH-1:0];
    assign div_lo = {acc_lo[WIDTH-2:0], div_ge};

    assign hi_nx = is_div ? div_hi : mul_hi;
    assign lo_nx = is_div ? div_lo : mul_lo;
`else
    assign hi_nx = mul_hi;
    assign lo_nx = mul_lo;
`endif

    assign last = step && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge CLK) begin
        if (CLR) begin
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            cnt    <= '0;
`ifdef SEQ_ALU_DIVIDE_EN
            is_div <= 1'b0;
`endif
        end else if (load) begin
            acc_hi <= '0;
            acc_lo <= a;
            opnd   <= b;
            cnt    <= '0;
`ifdef SEQ_ALU_DIVIDE_EN
            is_div <= div;
`endif
        end else if (step) begin
            acc_hi <= hi_nx;
            acc_lo <= lo_nx;
            cnt    <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU top: FSM, single-cycle ops, operand capture and the mem register.
// Define SEQ_ALU_DIVIDE_EN to build the iterative divider; otherwise DIV is an unknown opcode.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             start,
    input  logic [4:0]       f,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             v,
    input  logic             save,
    input  logic             load,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             err
);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] mem;
    logic [WIDTH-1:0] opa;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   dif_w;
    logic [WIDTH-1:0] alu_y;
    logic             alu_err;
    logic [WIDTH-1:0] res_y;
    logic             res_err;
    logic             accept;
    logic             iter_op;
    logic             wr_res;
    logic             wr_save;
    logic             v_p0;
    logic             save_p0;
    logic             md_last;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
`ifdef SEQ_ALU_DIVIDE_EN
    logic             dz_p0;
`endif

    assign opa    = load ? mem : a;
    assign accept = start && (state != RUN);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign sum_w  = {1'b0, opa} + {1'b0, b};
    assign dif_w  = {1'b0, opa} - {1'b0, b};

    always_comb begin
        iter_op = (f == OP_MUL);
`ifdef SEQ_ALU_DIVIDE_EN
        iter_op = iter_op || (f == OP_DIV);
`endif
    end

    // Single-cycle results; MUL/DIV land in the default arm but are never written from here.
    always_comb begin
        alu_y   = '0;
        alu_err = 1'b0;
        case (f)
            OP_ADD:  alu_y = v ? WIDTH'(sum_w[WIDTH]) : sum_w[WIDTH-1:0];
            OP_SUB:  alu_y = v ? {WIDTH{dif_w[WIDTH]}} : dif_w[WIDTH-1:0];
            OP_AND:  alu_y = opa & b;
            OP_OR:   alu_y = opa | b;
            OP_SHL:  alu_y = {opa[WIDTH-2:0], 1'b0};
            OP_SHR:  alu_y = {1'b0, opa[WIDTH-1:1]};
            default: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        wr_res   = 1'b0;
        wr_save  = 1'b0;
        res_y    = alu_y;
        res_err  = alu_err;
        case (state)
            IDLE, DONE: begin
                state_nx = IDLE;
                if (start) begin
                    if (iter_op) begin
                        state_nx = RUN;
                    end else begin
                        state_nx = DONE;
                        wr_res   = 1'b1;
                        wr_save  = save;
                    end
                end
            end
            RUN: begin
                if (md_last) begin
                    state_nx = DONE;
                    wr_res   = 1'b1;
                    wr_save  = save_p0;
                    res_y    = v_p0 ? md_hi : md_lo;
`ifdef SEQ_ALU_DIVIDE_EN
                    res_err  = dz_p0;
`else
                    res_err  = 1'b0;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Capture stage: result-select and save flag travel with the iterative op until it finishes.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            y       <= '0;
            err     <= 1'b0;
            mem     <= '0;
            v_p0    <= 1'b0;
            save_p0 <= 1'b0;
`ifdef SEQ_ALU_DIVIDE_EN
            dz_p0   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                v_p0    <= v;
                save_p0 <= save;
`ifdef SEQ_ALU_DIVIDE_EN
                dz_p0   <= (f == OP_DIV) && (b == '0);
`endif
            end
            if (wr_res) begin
                y   <= res_y;
                err <= res_err;
                if (wr_save) mem <= res_y;
            end
        end
    end

    seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .CLK   (CLK),
        .CLR   (CLR),
        .load  (accept && iter_op),
        .step  (state == RUN),
`ifdef SEQ_ALU_DIVIDE_EN
        .div   (f == OP_DIV),
`endif
        .a     (opa),
        .b     (b),
        .last  (md_last),
        .hi_nx (md_hi),
        .lo_nx (md_lo)
    );

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH=4 and WIDTH=8; DIV expectations follow SEQ_ALU_DIVIDE_EN.
module tb_seq_alu;

    localparam logic [4:0] OP_SHL = 5'b00000;
    localparam logic [4:0] OP_ADD = 5'b00010;
    localparam logic [4:0] OP_SUB = 5'b00011;
    localparam logic [4:0] OP_MUL = 5'b00100;
    localparam logic [4:0] OP_DIV = 5'b00110;
    localparam logic [4:0] OP_AND = 5'b01000;
    localparam logic [4:0] OP_OR  = 5'b01100;
    localparam logic [4:0] OP_SHR = 5'b10000;

    logic       CLK = 1'b0;
    logic       CLR;
    logic       start4, v4, save4, load4, busy4, done4, err4;
    logic [4:0] f4;
    logic [3:0] a4, b4, y4;
    logic       start8, v8, save8, load8, busy8, done8, err8;
    logic [4:0] f8;
    logic [7:0] a8, b8, y8;

    always #5 CLK = ~CLK;

    seq_alu #(.WIDTH(4)) u4 (
        .CLK(CLK), .CLR(CLR), .start(start4), .f(f4), .a(a4), .b(b4), .v(v4),
        .save(save4), .load(load4), .busy(busy4), .done(done4), .y(y4), .err(err4)
    );

    seq_alu #(.WIDTH(8)) u8 (
        .CLK(CLK), .CLR(CLR), .start(start8), .f(f8), .a(a8), .b(b8), .v(v8),
        .save(save8), .load(load8), .busy(busy8), .done(done8), .y(y8), .err(err8)
    );

    typedef struct {
        logic [15:0] y;
        logic        err;
        int          lat;
        int          t0;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];
    exp_t e4, e8;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, want);
        end
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (done4 === 1'b1) begin
            if (q4.size() == 0) begin
                total++; bad++;
                $display("FAIL w4 unexpected done: y=%0h err=%0b, want no done", y4, err4);
            end else begin
                e4 = q4.pop_front();
                chk("w4 y", {12'b0, y4}, e4.y);
                chk("w4 err", {15'b0, err4}, {15'b0, e4.err});
                chk("w4 latency", 16'(cyc - e4.t0), 16'(e4.lat));
            end
        end
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                total++; bad++;
                $display("FAIL w8 unexpected done: y=%0h err=%0b, want no done", y8, err8);
            end else begin
                e8 = q8.pop_front();
                chk("w8 y", {8'b0, y8}, e8.y);
                chk("w8 err", {15'b0, err8}, {15'b0, e8.err});
                chk("w8 latency", 16'(cyc - e8.t0), 16'(e8.lat));
            end
        end
    end

    task automatic go4(input logic [4:0] f, input logic [3:0] a, input logic [3:0] b,
                       input logic v, input logic sv, input logic ld,
                       input logic [3:0] ey, input logic ee, input int lat, input bit push);
        f4 = f; a4 = a; b4 = b; v4 = v; save4 = sv; load4 = ld; start4 = 1'b1;
        if (push) q4.push_back('{y: {12'b0, ey}, err: ee, lat: lat, t0: cyc});
        @(negedge CLK);
        start4 = 1'b0; save4 = 1'b0; load4 = 1'b0;
    endtask

    task automatic go8(input logic [4:0] f, input logic [7:0] a, input logic [7:0] b,
                       input logic v, input logic [7:0] ey, input logic ee, input int lat);
        f8 = f; a8 = a; b8 = b; v8 = v; start8 = 1'b1;
        q8.push_back('{y: {8'b0, ey}, err: ee, lat: lat, t0: cyc});
        @(negedge CLK);
        start8 = 1'b0;
    endtask

    task automatic drain4(input string nm, output int nb);
        int n = 0;
        nb = 0;
        while (q4.size() != 0 && n < 40) begin
            if (busy4 === 1'b1) nb++;
            @(negedge CLK);
            n++;
        end
        total++;
        if (q4.size() != 0) begin
            bad++;
            $display("FAIL %s timeout: pending=%0d, want 0", nm, q4.size());
            q4.delete();
        end
    endtask

    task automatic drain8(input string nm, output int nb);
        int n = 0;
        nb = 0;
        while (q8.size() != 0 && n < 40) begin
            if (busy8 === 1'b1) nb++;
            @(negedge CLK);
            n++;
        end
        total++;
        if (q8.size() != 0) begin
            bad++;
            $display("FAIL %s timeout: pending=%0d, want 0", nm, q8.size());
            q8.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int n;
        CLR = 1'b1;
        start4 = 0; f4 = '0; a4 = '0; b4 = '0; v4 = 0; save4 = 0; load4 = 0;
        start8 = 0; f8 = '0; a8 = '0; b8 = '0; v8 = 0; save8 = 0; load8 = 0;
        repeat (3) @(negedge CLK);
        CLR = 1'b0;
        chk("reset y4", {12'b0, y4}, 16'h0);
        chk("reset busy4", {15'b0, busy4}, 16'h0);
        chk("reset done4", {15'b0, done4}, 16'h0);
        chk("reset err4", {15'b0, err4}, 16'h0);
        chk("reset y8", {8'b0, y8}, 16'h0);

        // Single-cycle arithmetic and logic, a=1110 b=0110
        go4(OP_ADD, 4'b1110, 4'b0110, 0, 0, 0, 4'b0100, 0, 1, 1); drain4("add", nb);
        go4(OP_ADD, 4'b1110, 4'b0110, 1, 0, 0, 4'b0001, 0, 1, 1); drain4("add carry", nb);
        go4(OP_SUB, 4'b1110, 4'b0110, 0, 1, 0, 4'b1000, 0, 1, 1); drain4("sub save", nb);
        go4(OP_ADD, 4'b0001, 4'b0001, 0, 0, 0, 4'b0010, 0, 1, 1); drain4("add nosave", nb);
        go4(OP_AND, 4'b0000, 4'b1100, 0, 0, 1, 4'b1000, 0, 1, 1); drain4("and load", nb);
        go4(OP_SUB, 4'b0011, 4'b0101, 1, 0, 0, 4'b1111, 0, 1, 1); drain4("sub borrow", nb);
        go4(OP_SUB, 4'b0101, 4'b0011, 1, 0, 0, 4'b0000, 0, 1, 1); drain4("sub noborrow", nb);
        go4(OP_SHL, 4'b1011, 4'b0000, 0, 0, 0, 4'b0110, 0, 1, 1); drain4("shl", nb);
        go4(OP_SHR, 4'b1011, 4'b0000, 0, 0, 0, 4'b0101, 0, 1, 1); drain4("shr", nb);
        go4(OP_OR,  4'b1010, 4'b0101, 0, 0, 0, 4'b1111, 0, 1, 1); drain4("or", nb);
        go4(5'b11111, 4'b1110, 4'b0110, 0, 0, 0, 4'b0000, 1, 1, 1); drain4("unknown op", nb);

        // Iterative multiply: busy for exactly WIDTH cycles
        go4(OP_MUL, 4'b1110, 4'b0110, 1, 0, 0, 4'b0101, 0, 5, 1); drain4("mul hi", nb);
        chk("mul hi busy cycles", 16'(nb), 16'd4);
        go4(OP_MUL, 4'b1110, 4'b0110, 0, 0, 0, 4'b0100, 0, 5, 1); drain4("mul lo", nb);

`ifdef SEQ_ALU_DIVIDE_EN
        go4(OP_DIV, 4'b1110, 4'b0110, 0, 0, 0, 4'b0010, 0, 5, 1); drain4("div quo", nb);
        chk("div busy cycles", 16'(nb), 16'd4);
        go4(OP_DIV, 4'b1110, 4'b0110, 1, 0, 0, 4'b0010, 0, 5, 1); drain4("div rem", nb);
        go4(OP_DIV, 4'b0110, 4'b0000, 0, 0, 0, 4'b1111, 1, 5, 1); drain4("div0 quo", nb);
        go4(OP_DIV, 4'b0110, 4'b0000, 1, 0, 0, 4'b0110, 1, 5, 1); drain4("div0 rem", nb);
`else
        go4(OP_DIV, 4'b1110, 4'b0110, 0, 0, 0, 4'b0000, 1, 1, 1); drain4("div absent", nb);
        chk("div absent busy cycles", 16'(nb), 16'd0);
        go4(OP_DIV, 4'b0110, 4'b0000, 0, 0, 0, 4'b0000, 1, 1, 1); drain4("div0 absent", nb);
`endif

        // Start and operand changes during RUN must be ignored
        go4(OP_MUL, 4'b1110, 4'b0110, 1, 0, 0, 4'b0101, 0, 5, 1);
        @(negedge CLK);
        go4(OP_ADD, 4'b0001, 4'b0001, 0, 1, 0, 4'b0000, 0, 1, 0);
        drain4("mul with start in run", nb);
        repeat (3) @(negedge CLK);

        // CLR on the 2nd RUN cycle aborts the multiply without done or mem write
        go4(OP_SUB, 4'b1110, 4'b0110, 0, 1, 0, 4'b1000, 0, 1, 1); drain4("sub save 2", nb);
        go4(OP_MUL, 4'b1110, 4'b0110, 1, 1, 0, 4'b0000, 0, 5, 0);
        @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        chk("abort busy", {15'b0, busy4}, 16'h0);
        chk("abort y", {12'b0, y4}, 16'h0);
        chk("abort done", {15'b0, done4}, 16'h0);
        repeat (6) @(negedge CLK);
        go4(OP_AND, 4'b0000, 4'b1111, 0, 0, 1, 4'b0000, 0, 1, 1); drain4("mem cleared", nb);

        // CLR wins over a simultaneous start
        CLR = 1'b1;
        go4(OP_ADD, 4'b0011, 4'b0011, 0, 0, 0, 4'b0000, 0, 1, 0);
        CLR = 1'b0;
        chk("clr priority done", {15'b0, done4}, 16'h0);
        chk("clr priority y", {12'b0, y4}, 16'h0);
        repeat (3) @(negedge CLK);

        // WIDTH=8: multiply, then a back-to-back start in the DONE cycle
        go8(OP_ADD, 8'd200, 8'd100, 0, 8'h2C, 0, 1); drain8("w8 add", nb);
        go8(OP_ADD, 8'd200, 8'd100, 1, 8'h01, 0, 1); drain8("w8 add carry", nb);
        go8(OP_MUL, 8'b11001000, 8'b00000011, 1, 8'b00000010, 0, 9);
        n = 0;
        while (done8 !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("w8 reach done", {15'b0, done8}, 16'h1);
        go8(OP_MUL, 8'b11001000, 8'b00000011, 0, 8'b01011000, 0, 9);
        drain8("w8 back-to-back", nb);
        chk("w8 busy cycles", 16'(nb), 16'd8);
        repeat (3) @(negedge CLK);

        chk("w4 queue empty", 16'(q4.size()), 16'd0);
        chk("w8 queue empty", 16'(q8.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits (legal range 2..16).
REQ-002 Port: CLK  input  1  rising-edge clock; single clock domain.
REQ-003 Port: CLR  input  1  reset; synchronous, active-high.
REQ-004 Port: start  input  1  operation request; sampled only while busy=0.
REQ-005 Port: f  input  5  opcode; captured on start.
REQ-006 Port: a, b  input  WIDTH  operands; captured on start.
REQ-007 Port: v  input  1  result-select (high half, carry, or remainder); captured on start.
REQ-008 Port: save, load  input  1  save: store result in mem on done; load: use mem instead of a as operand A; both captured on start.
REQ-009 Port: busy  output  1  high while an iterative operation runs.
REQ-010 Port: done  output  1  one-cycle pulse, result valid.
REQ-011 Port: y  output  WIDTH  result; holds its value until the next done.
REQ-012 Port: err  output  1  valid with done; high for an unknown opcode or divide-by-zero.

Function
REQ-013 FSM states: IDLE, RUN, DONE; start accepted in IDLE or DONE, giving back-to-back operation; start while busy is ignored.
REQ-014 Single-cycle ops go start -> DONE; done is high in the cycle after the start edge (latency 1).
REQ-015 MUL and DIV go start -> RUN for exactly WIDTH cycles (one shift-add or restoring step each) -> DONE; latency WIDTH+1; busy=1 only in RUN.
REQ-016 Opcodes on captured operand A:
  00010 ADD: v ? zero-extended carry : sum mod 2^WIDTH.
  00011 SUB: v ? borrow replicated across WIDTH : difference mod 2^WIDTH.
  01000 AND; 01100 OR.
  00000 SHL: A<<1 with zero fill.
  10000 SHR: A>>1 logical.
  00100 MUL: v ? product[2W-1:W] : product[W-1:0].
  00110 DIV: v ? remainder : quotient (unsigned).
REQ-017 Divide-by-zero (b=0) gives quotient all-ones, remainder = A, err=1, and the same latency as a normal divide.
REQ-018 Any other opcode gives y=0 and err=1 with latency 1.
REQ-019 mem is WIDTH bits; it is written with y in the DONE cycle only when save was captured high; load reads mem as it was at the start edge.
REQ-020 Inputs changing during RUN have no effect on the result.

Reset
REQ-021 CLR=1 at a clock edge forces IDLE, y=0, mem=0, busy=0, done=0, err=0, and clears the iteration counter and datapath registers.
REQ-022 CLR during RUN aborts the operation: no done, and mem is not written.
REQ-023 CLR has priority over a simultaneous start.

Configuration
REQ-024 Macro SEQ_ALU_DIVIDE_EN defined: DIV is implemented per REQ-015 to REQ-017.
REQ-025 Without SEQ_ALU_DIVIDE_EN: no divider logic is built, and opcode 00110 behaves as an unknown opcode per REQ-018.

Structure
REQ-026 Package seq_alu_pkg holds the opcode constants, the FSM state type, and WIDTH bounds.
REQ-027 Sub-module seq_alu_muldiv holds the iterative multiply/divide datapath and counter; the top holds the FSM, single-cycle ops, mem, and capture registers.

Verification
REQ-028 WIDTH=4, a=1110, b=0110: ADD v=0 -> y=0100, v=1 -> y=0001; SUB v=0 -> y=1000, err=0; each with done 1 cycle after start.
REQ-029 WIDTH=4, same operands: MUL v=1 -> y=0101, v=0 -> y=0100; DIV v=0 -> y=0010, v=1 -> y=0010; done exactly 5 cycles after start, busy high 4 cycles.
REQ-030 WIDTH=4: SUB with save=1 (mem=1000), then AND with load=1 and b=1100 -> y=1000; DIV with b=0000, a=0110 -> y=1111, err=1; f=11111 -> y=0000, err=1.
REQ-031 WIDTH=4: CLR=1 on the 2nd RUN cycle of a MUL -> next cycle busy=0, y=0000, no done pulse, mem=0000; start during RUN is ignored (single done).
REQ-032 WIDTH=8, a=11001000, b=00000011: MUL v=1 -> y=00000010, v=0 -> y=01011000 after 9 cycles; back-to-back start in the DONE cycle is accepted.
REQ-033 Build without SEQ_ALU_DIVIDE_EN: DIV -> y=0, err=1, latency 1.
